// File: rtl/line_unrotator.sv
// line_unrotator: undoes the per-line cyclic rotation of BT.656 active video
// using two ping-pong line banks, one line of latency plus one output register.
module line_unrotator #(
  parameter int ACTIVE_SAMPLES = 1440,
  parameter int LINE_SAMPLES   = 1716,
  parameter int CUT_SHIFT      = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [9:0] data_in,
  input  logic [7:0] raw_cut_position,
  input  logic       H,
  input  logic       V,
  output logic [9:0] data_out,
  output logic       data_valid
);
  localparam int PW = $clog2(LINE_SAMPLES);
  localparam int AW = $clog2(ACTIVE_SAMPLES + 1);
  localparam logic [PW-1:0] POS_MAX = PW'(LINE_SAMPLES - 1);
  localparam logic [AW-1:0] A_END = AW'(ACTIVE_SAMPLES);
  logic [9:0] mem [0:1][0:LINE_SAMPLES-1];
  logic [PW-1:0] pos_q, pos_d, base_q, base_d, eff_pos, eff_base;
  logic [AW-1:0] a_q, a_d, cut_q, cut_d, eff_a, eff_cut, raw_mod;
  logic [AW:0] sum, wrapped;
  logic [PW:0] act_addr, wr_full;
  logic [9:0] data_out_q, data_out_d;
  logic bank_q, bank_d, run_q, run_d, h_prev_q, h_prev_d, seen_q, seen_d, valid_q, valid_d;
  logic h_rise, h_fall, live, ovf, wr_bank, first_act, active, act_ok, we;
  always_comb begin
    h_rise    = H & ~h_prev_q;
    h_fall    = ~H & h_prev_q;
    live      = h_rise | run_q;
    ovf       = ~h_rise & (pos_q == POS_MAX);
    eff_pos   = h_rise ? '0 : ovf ? pos_q : pos_q + 1'b1;
    wr_bank   = h_rise ? ~bank_q : bank_q;
    first_act = live & h_fall & ~V;
    active    = live & ~H & ~V;
    raw_mod   = AW'((32'(raw_cut_position) << CUT_SHIFT) % ACTIVE_SAMPLES);
    eff_a     = first_act ? '0 : a_q;
    eff_cut   = first_act ? raw_mod : cut_q;
    eff_base  = first_act ? eff_pos : base_q;
    // rotation undone by writing each active sample to its original slot
    sum       = {1'b0, eff_a} + {1'b0, eff_cut};
    wrapped   = sum >= (AW+1)'(ACTIVE_SAMPLES) ? sum - (AW+1)'(ACTIVE_SAMPLES) : sum;
    act_ok    = active & (eff_a < A_END);
    act_addr  = {1'b0, eff_base} + (PW+1)'(wrapped);
    wr_full   = act_ok ? act_addr : {1'b0, eff_pos};
    we        = live & ~ovf & (~active | act_ok) & (wr_full < (PW+1)'(LINE_SAMPLES));
  end
  always_comb begin
    h_prev_d   = H;
    run_d      = live;
    pos_d      = live ? eff_pos : pos_q;
    bank_d     = wr_bank;
    a_d        = h_rise ? A_END : act_ok ? eff_a + 1'b1 : a_q;
    cut_d      = first_act ? raw_mod : cut_q;
    base_d     = first_act ? eff_pos : base_q;
    seen_d     = seen_q | h_rise;
    valid_d    = valid_q | (h_rise & seen_q);
    data_out_d = live ? mem[~wr_bank][eff_pos] : '0;
  end
  always_ff @(posedge clk) begin
    if (we) mem[wr_bank][wr_full[PW-1:0]] <= data_in;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pos_q      <= '0;
      a_q        <= '0;
      cut_q      <= '0;
      base_q     <= '0;
      bank_q     <= 1'b0;
      run_q      <= 1'b0;
      h_prev_q   <= 1'b1;
      seen_q     <= 1'b0;
      valid_q    <= 1'b0;
      data_out_q <= '0;
    end else begin
      pos_q      <= pos_d;
      a_q        <= a_d;
      cut_q      <= cut_d;
      base_q     <= base_d;
      bank_q     <= bank_d;
      run_q      <= run_d;
      h_prev_q   <= h_prev_d;
      seen_q     <= seen_d;
      valid_q    <= valid_d;
      data_out_q <= data_out_d;
    end
  end
  assign data_out   = data_out_q;
  assign data_valid = valid_q;
endmodule

// File: tb/tb_line_unrotator.sv
// tb_line_unrotator: random and directed lines checked against a line-level
// model of the unrotation (output active j = input active (j - cut) mod N).
module tb_line_unrotator;
  localparam int AS = 1440;
  localparam int LS = 1716;
  localparam int BL = LS - AS;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [9:0] data_in = '0;
  logic [7:0] raw_cut_position = '0;
  logic H = 1'b0;
  logic V = 1'b0;
  logic [9:0] data_out;
  logic data_valid;
  int n_chk = 0;
  int n_fail = 0;
  logic [9:0] cur [LS];
  logic [9:0] exp_line [LS];
  bit have_prev = 0;
  int prev_kind = -1;
  always #5 clk = ~clk;
  line_unrotator dut (
    .clk(clk), .reset_n(reset_n), .data_in(data_in),
    .raw_cut_position(raw_cut_position), .H(H), .V(V),
    .data_out(data_out), .data_valid(data_valid)
  );
  task automatic chk(input string tag, input int got, input int want);
    n_chk++;
    if (got != want) begin
      n_fail++;
      if (n_fail <= 20) $display("FAIL %s: got %0d, want %0d", tag, got, want);
    end
  endtask
  task automatic idle(input int n);
    H = 1'b0;
    V = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
      chk("idle_valid", data_valid, have_prev);
    end
  endtask
  // kind: 0 random, 1 position ramp, 2 active pre-rotated by 4, 3 active-index ramp
  task automatic run_line(input bit v, input logic [7:0] rc, input int kind, input int rst_at);
    int a, cut, d;
    cut = (int'(rc) << 2) % AS;
    for (int p = 0; p < LS; p++) begin
      a = p - BL;
      H = p < BL;
      V = v;
      raw_cut_position = rc;
      d = kind == 1 ? p : (kind == 2 && a >= 0) ? (a + 4) % AS : (kind == 3 && a >= 0) ? a : int'($urandom);
      data_in = 10'(d);
      cur[p] = data_in;
      if (p == rst_at) begin
        reset_n = 1'b0;
        #1;
        chk("rst_data_out", data_out, 0);
        chk("rst_valid", data_valid, 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        have_prev = 0;
        prev_kind = -1;
        return;
      end
      @(posedge clk);
      #1;
      chk("valid", data_valid, have_prev);
      if (have_prev) begin
        chk("data", data_out, exp_line[p]);
        if (prev_kind == 2 && a >= 0) chk("restore", data_out, a & 1023);
        if (prev_kind == 3 && a == 1019) chk("wrap1019", data_out, 1439 & 1023);
        if (prev_kind == 3 && a == 1020) chk("wrap1020", data_out, 0);
      end
    end
    for (int p = 0; p < LS; p++)
      exp_line[p] = (p < BL || v) ? cur[p] : cur[BL + ((p - BL - cut + AS) % AS)];
    have_prev = 1;
    prev_kind = kind;
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_data_out", data_out, 0);
    chk("reset_valid", data_valid, 0);
    reset_n = 1'b1;
    idle(4);
    run_line(1'b0, 8'd0, 1, -1);
    run_line(1'b0, 8'd0, 1, -1);
    run_line(1'b0, 8'd1, 2, -1);
    run_line(1'b0, 8'd255, 3, -1);
    run_line(1'b1, 8'd37, 0, -1);
    run_line(1'b0, 8'($urandom), 0, -1);
    for (int i = 0; i < 5; i++)
      run_line($urandom_range(0, 3) == 0, 8'($urandom), 0, -1);
    run_line(1'b0, 8'($urandom), 0, 800);
    idle(5);
    for (int i = 0; i < 3; i++)
      run_line(1'b0, 8'($urandom), 0, -1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
